instr_issue_ctrl: RTL and testbench
===================================

INSTR_ISSUE_CTRL -- requirements
Module: instr_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction FIFO depth in words (power of two, 2..16).
REQ-002 SHALL have parameter BUBBLE_WORD, default 16'h0000, meaning the word driven to the CPU when no instruction is queued.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  host offers an instruction word.
REQ-006 SHALL have port in_data  input  16  host instruction word.
REQ-007 SHALL have port in_ready  output  1  controller accepts the word this cycle.
REQ-008 SHALL have port start  input  1  begin or resume issuing.
REQ-009 SHALL have port halt  input  1  stop issuing after the current cycle.
REQ-010 SHALL have port flush  input  1  discard all queued words.
REQ-011 SHALL have port cpu_done  input  1  CPU ready for its next instruction.
REQ-012 SHALL have port cpu_din  output  16  instruction word presented to the CPU.
REQ-013 SHALL have port issue_valid  output  1  one-cycle pulse: cpu_din was updated this cycle.
REQ-014 SHALL have port busy  output  1  high in RUN state.
REQ-015 SHALL have ports empty, full  output  1 each  FIFO status.
REQ-016 SHALL have port issued_cnt  output  16  queued words issued since reset.
REQ-017 SHALL have port bubble_cnt  output  8  bubbles issued since reset.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and HALTED.
REQ-019 Transitions SHALL be: IDLE->RUN on start; RUN->HALTED on halt; HALTED->RUN on start; halt and start in the same cycle in RUN means halt wins; in IDLE or HALTED, start wins.
REQ-020 SHALL raise an issue request on a cycle in RUN where cpu_done=1 and cpu_done was 0 in the previous cycle.
REQ-021 SHALL also raise an issue request on the first RUN cycle if cpu_done=1 on that cycle.
REQ-022 On an issue request with FIFO not empty: pop the head into cpu_din, pulse issue_valid, increment issued_cnt (wraps modulo 2^16).
REQ-023 On an issue request with FIFO empty: load BUBBLE_WORD into cpu_din, pulse issue_valid, increment bubble_cnt (saturates at 255).
REQ-024 cpu_din SHALL update on the clock edge that ends the request cycle; that is a registered output with 1-cycle latency from the cpu_done rising edge.
REQ-025 cpu_din SHALL hold its value between issues.
REQ-026 A level-high cpu_done SHALL produce no further issues until it falls and rises again.
REQ-027 in_ready SHALL equal !full in every state; a push occurs when in_valid && in_ready.
REQ-028 Push and pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-029 A push while empty plus an issue request in the same cycle SHALL issue a bubble; the pushed word is stored.
REQ-030 flush SHALL empty the FIFO in IDLE or HALTED and SHALL be ignored in RUN.
REQ-031 A push coincident with an accepted flush SHALL be discarded.
REQ-032 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked as 0..DEPTH without ambiguity.
REQ-033 In IDLE and HALTED, SHALL NOT issue; cpu_done edges are tracked but ignored, and queued words are retained.
REQ-034 busy SHALL be 1 exactly when state is RUN.

Reset
REQ-035 Assertion of reset (low) SHALL immediately, without a clock, force: state IDLE, FIFO empty (empty=1, full=0, in_ready=1), cpu_din=BUBBLE_WORD, issue_valid=0, busy=0, issued_cnt=0, bubble_cnt=0, previous-cpu_done register=0.
REQ-036 Reset asserted mid-RUN SHALL discard queued words and any pending issue.
REQ-037 After reset deasserts, first state change SHALL occur on the next rising clk edge.

Verification
REQ-038 Push 16'h1234 and 16'h5678, start, cpu_done rising twice -> cpu_din=16'h1234 then 16'h5678, two issue_valid pulses, issued_cnt=2, bubble_cnt=0.
REQ-039 Push DEPTH words with in_valid held -> full=1 and in_ready=0; the DEPTH+1th word is not accepted; after one issue, in_ready=1 again.
REQ-040 Start with FIFO empty, then cpu_done rises -> cpu_din=BUBBLE_WORD, bubble_cnt=1; run 300 bubbles -> bubble_cnt=255.
REQ-041 Hold cpu_done high 10 cycles in RUN with 3 words queued -> exactly one issue_valid pulse.
REQ-042 halt and start in the same RUN cycle -> HALTED, busy=0; flush in HALTED -> empty=1; flush in RUN -> no effect.
REQ-043 Assert reset mid-RUN with 2 words queued -> all outputs at reset values with no clock edge; a later start with cpu_done rising issues a bubble.

Source files
------------

// File: rtl/instr_issue_ctrl.sv
// Instruction issue controller: buffers host words in a small FIFO and hands
// one word (or a bubble) to the CPU on each rising edge of cpu_done while running.
module instr_issue_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [15:0] BUBBLE_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        start,
  input  logic        halt,
  input  logic        flush,
  input  logic        cpu_done,
  output logic [15:0] cpu_din,
  output logic        issue_valid,
  output logic        busy,
  output logic        empty,
  output logic        full,
  output logic [15:0] issued_cnt,
  output logic [7:0]  bubble_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          prev_done, prev_run;
  logic          issue_req, do_flush, push, pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign busy     = (state == RUN);

  // Edge-qualified request; the first RUN cycle counts as an edge if cpu_done is already high.
  assign issue_req = (state == RUN) && cpu_done && (!prev_done || !prev_run);
  assign do_flush  = flush && (state != RUN);
  assign push      = in_valid && in_ready && !do_flush;
  assign pop       = issue_req && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (halt)  state_nxt = HALTED;
      HALTED:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_done <= 1'b0;
      prev_run  <= 1'b0;
    end else begin
      prev_done <= cpu_done;
      prev_run  <= (state == RUN);
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (do_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_din     <= BUBBLE_WORD;
      issue_valid <= 1'b0;
      issued_cnt  <= '0;
      bubble_cnt  <= '0;
    end else begin
      issue_valid <= issue_req;
      if (issue_req) cpu_din <= empty ? BUBBLE_WORD : mem[rptr];
      if (pop) issued_cnt <= issued_cnt + 16'd1;
      if (issue_req && empty && bubble_cnt != 8'hFF) bubble_cnt <= bubble_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl with a scoreboard of expected issued words.
module tb_instr_issue_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] BUB   = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, start, halt, flush, cpu_done;
  logic [15:0] in_data;
  logic        in_ready, issue_valid, busy, empty, full;
  logic [15:0] cpu_din, issued_cnt;
  logic [7:0]  bubble_cnt;

  int total = 0;
  int bad   = 0;
  int n_iss = 0;
  int exp_iss = 0;
  int exp_bub = 0;
  logic [15:0] mq[$];     // model of FIFO contents
  logic [15:0] exp_q[$];  // words expected on cpu_din, in order

  instr_issue_ctrl #(.DEPTH(DEPTH), .BUBBLE_WORD(BUB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .start(start), .halt(halt), .flush(flush),
    .cpu_done(cpu_done), .cpu_din(cpu_din), .issue_valid(issue_valid),
    .busy(busy), .empty(empty), .full(full), .issued_cnt(issued_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (issue_valid === 1'b1) begin
      n_iss++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_issue observed=%h expected=none", cpu_din);
      end
      if (exp_q.size() != 0) chk("cpu_din", {16'h0, cpu_din}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    mq.push_back(d);
  endtask

  task automatic expect_issue();
    if (mq.size() != 0) begin
      exp_q.push_back(mq.pop_front());
      exp_iss++;
    end else begin
      exp_q.push_back(BUB);
      if (exp_bub < 255) exp_bub++;
    end
  endtask

  task automatic pulse();
    expect_issue();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    tick();
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_issued"}, {16'h0, issued_cnt}, exp_iss);
    chk({tag, "_bubble"}, {24'h0, bubble_cnt}, exp_bub);
  endtask

  initial begin
    int base;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; start = 1'b0;
    halt = 1'b0; flush = 1'b0; cpu_done = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cpu_din", cpu_din, BUB);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_busy", busy, 0);
    chk_counts("rst");
    #10 reset = 1'b1;
    tick();

    // two words, start, two cpu_done edges
    push_word(16'h1234);
    push_word(16'h5678);
    chk("two_empty", empty, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("run_busy", busy, 1);
    pulse();
    pulse();
    chk("hold_cpu_din", cpu_din, 16'h5678);
    chk_counts("two");
    chk("two_drained", empty, 1);

    // fill to DEPTH, offer one more, then one issue frees a slot
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 16'hA000 + 16'(i);
      mq.push_back(in_data);
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    in_data = 16'hDEAD;
    tick();
    in_valid = 1'b0;
    chk("over_full", full, 1);
    pulse();
    chk("after_pop_in_ready", in_ready, 1);
    for (int i = 1; i < DEPTH; i++) pulse();
    chk("fill_drained", empty, 1);

    // cpu_done held high 10 cycles -> one issue only
    push_word(16'hB001); push_word(16'hB002); push_word(16'hB003);
    base = n_iss;
    expect_issue();
    cpu_done = 1'b1;
    repeat (10) tick();
    cpu_done = 1'b0;
    tick();
    chk("level_one_issue", n_iss - base, 1);
    pulse(); pulse();
    chk_counts("level");

    // halt+start together in RUN -> HALTED
    halt = 1'b1; start = 1'b1; tick(); halt = 1'b0; start = 1'b0;
    chk("halt_wins_busy", busy, 0);
    push_word(16'hC001);
    base = n_iss;
    cpu_done = 1'b1; tick(); cpu_done = 1'b0; tick(); tick();
    chk("halted_no_issue", n_iss - base, 0);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    mq.delete();
    chk("flush_halted_empty", empty, 1);
    push_word(16'hC0DE);
    // cpu_done already high when RUN is re-entered
    cpu_done = 1'b1; tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    expect_issue();
    tick();
    cpu_done = 1'b0; tick();
    chk("resume_busy", busy, 1);
    push_word(16'hD00D);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_run_ignored", empty, 0);
    pulse();

    // push into empty FIFO while issuing -> bubble, word kept
    expect_issue();
    mq.push_back(16'hE1E1);
    in_valid = 1'b1; in_data = 16'hE1E1; cpu_done = 1'b1;
    tick();
    in_valid = 1'b0; cpu_done = 1'b0;
    tick();
    chk("push_bubble_kept", empty, 0);
    chk_counts("push_bubble");
    pulse();

    // bubble counter saturates
    pulse();
    chk_counts("bubble_one");
    repeat (300) pulse();
    chk("bubble_sat", bubble_cnt, 255);

    // reset mid-RUN with words queued
    push_word(16'hF001); push_word(16'hF002);
    #2 reset = 1'b0;
    #1;
    mq.delete(); exp_iss = 0; exp_bub = 0;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_cpu_din", cpu_din, BUB);
    chk("mid_rst_issue_valid", issue_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk_counts("mid_rst");
    tick();
    reset = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    pulse();
    chk_counts("post_rst");
    chk("post_rst_cpu_din", cpu_din, BUB);
    tick();
    chk("pending_issues", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
